ro_edge_counter: RTL and testbench
==================================

Name: ro_edge_counter

Overview:
- Measurement stage directly downstream of the ring-oscillator tap.
- Synchronises the free-running oscillator output into the `clk` domain and counts its rising edges over a programmable gate window of `clk` cycles.
- Reports a held count, a done pulse and an overflow flag, so oscillator frequency (and hence stage delay) is f_clk * count / gate_len.
- Valid for oscillator frequencies below f_clk/2. Faster taps must be pre-divided before this block.

Parameters:
- CNT_W, 16, width of edge counter and result register.
- GATE_W, 16, width of gate-length input and gate timer.
- SYNC_STAGES, 2, number of flops in the `ro_in` synchroniser (minimum 2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset: asynchronous, active-high. Clears all state.
- start, input, 1, request a measurement. Sampled only when busy=0.
- gate_len, input, GATE_W, window length in clk cycles. Sampled on accepted start. Value 0 is treated as 1.
- ro_in, input, 1, asynchronous oscillator tap.
- busy, output, 1, high while a measurement is in progress.
- done, output, 1, one-cycle pulse marking that count/overflow have been updated.
- count, output, CNT_W, rising edges seen in the last completed window. Held between measurements.
- overflow, output, 1, last window saturated the counter. Held with count.
- ro_sync, output, 1, synchronised ro_in, for debug/observation.

Behaviour:
- Reset values (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, count=0, overflow=0.
  - Synchroniser, edge-detect register, timer and accumulator all 0.
- Synchroniser:
  - SYNC_STAGES flops, always running, never gated by state.
  - ro_sync is the last stage.
- Edge detect:
  - prev register always tracks ro_sync.
  - edge = ro_sync & ~prev.
  - Because prev runs in every state, a static-high input produces no edge at window entry.
- FSM states: IDLE, ARM, GATE, DONE.
  - IDLE: busy=0. If start=1 at a clock edge → ARM; gate_len is latched, with 0 replaced by 1.
  - ARM (1 cycle): accumulator cleared, acc_ovf cleared, timer loaded with the latched length. → GATE.
  - GATE: lasts exactly N = latched length cycles.
    - Each cycle with edge=1 increments the accumulator.
    - At all-ones the accumulator saturates (holds all-ones) and sets acc_ovf.
    - The timer decrements each cycle. When it reaches 1 (last gated cycle) → DONE.
  - DONE (1 cycle): count ← accumulator (including the last gated cycle's edge), overflow ← acc_ovf, done=1. → IDLE.
- busy = 1 in ARM, GATE and DONE.
- start is ignored whenever busy=1, including the DONE cycle. It is not queued.
- Latency: start sampled at edge k → done high in the cycle after edge k+N+2, i.e. N+2 cycles after acceptance. Total occupancy is N+2 cycles.
- count and overflow change only on DONE. They are stable between done pulses and across idle periods.
- Synchroniser latency shifts the window relative to ro_in by SYNC_STAGES cycles. No correction is applied.
- Edge counting is exact for edges seen at ro_sync within the N gated cycles. Edges at ro_sync outside GATE are discarded.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No done pulse. Any partial count is lost.
- start asserted in the same cycle as rst: reset wins.
- gate_len may change freely while busy. Only the latched value is used.

Test Plan:
- ro_in period 8 clk (4 high/4 low), gate_len=80, start pulse → done exactly 82 cycles after acceptance, count=10, overflow=0, busy high for 82 cycles.
- ro_in held 1 before and through measurement, gate_len=50 → count=0, overflow=0. Confirms no spurious entry edge.
- CNT_W=4, ro_in period 4 clk, gate_len=100 → count=15 (saturated), overflow=1. A following run with ro_in static gives count=0, overflow=0.
- gate_len=0 with ro_in static 0 → treated as 1, done 3 cycles after acceptance, count=0.
- Second start pulse mid-GATE and in the DONE cycle → ignored: exactly one done pulse, count from the first window only.
- rst asserted asynchronously mid-GATE (ro_in period 8, gate_len=80), released, then fresh start → outputs 0 immediately with no done. The fresh run yields count=10.

Source files
------------

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: counts rising edges of a synchronised ring-oscillator tap over a gated window of clk cycles.
module ro_edge_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ro_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              ro_sync
);
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
  state_t state, next;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, rise, acc_ovf;
  logic [GATE_W-1:0] len, timer;
  logic [CNT_W-1:0] acc;
  assign ro_sync = sync[SYNC_STAGES-1];
  assign rise = ro_sync & ~prev;
  always_comb begin
    next = state == IDLE ? (start ? ARM : IDLE) :
           state == ARM  ? GATE :
           state == GATE ? (timer == GATE_W'(1) ? DONE : GATE) : IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      sync     <= '0;
      prev     <= 1'b0;
      len      <= '0;
      timer    <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next;
      sync  <= {sync[SYNC_STAGES-2:0], ro_in};
      prev  <= ro_sync;
      done  <= state == DONE;
      if (state == IDLE && start) len <= gate_len == '0 ? GATE_W'(1) : gate_len;
      if (state == ARM) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
        timer   <= len;
      end
      if (state == GATE) begin
        timer <= timer - GATE_W'(1);
        // saturate rather than wrap so a too-fast tap is flagged, not aliased
        if (rise && &acc) acc_ovf <= 1'b1;
        else if (rise) acc <= acc + CNT_W'(1);
      end
      if (state == DONE) begin
        count    <= acc;
        overflow <= acc_ovf;
      end
    end
endmodule

// File: tb/tb_ro_edge_counter.sv
// tb_ro_edge_counter: directed runs on a 16-bit and a 4-bit counter, scoreboard checks each done pulse.
module tb_ro_edge_counter;
  logic clk = 0, rst = 1, start = 0, ro_in = 0, lvl = 0;
  logic [15:0] gate_len = 0;
  logic busy, done, overflow, ro_sync, busy4, done4, overflow4, ro_sync4;
  logic [15:0] count;
  logic [3:0] count4;
  int hp = 0, cyc = 0, total = 0, bad = 0, bl = 0;
  bit pd = 0;
  typedef struct {int c16; bit o16; int c4; bit o4; int at; int bl;} exp_t;
  exp_t q[$];

  ro_edge_counter dut (.clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .ro_in(ro_in),
    .busy(busy), .done(done), .count(count), .overflow(overflow), .ro_sync(ro_sync));
  ro_edge_counter #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .ro_in(ro_in),
    .busy(busy4), .done(done4), .count(count4), .overflow(overflow4), .ro_sync(ro_sync4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3;
    forever begin
      if (hp == 0) begin ro_in = lvl; #10; end
      else begin ro_in = ~ro_in; #(hp * 10); end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bl = 0;
      pd = 0;
    end else begin
      if (busy) bl++;
      if (done) begin
        exp_t e;
        if (pd) chk("done_width", 2, 1);
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("count16", count, e.c16);
          chk("ovf16", overflow, e.o16);
          chk("count4", count4, e.c4);
          chk("ovf4", overflow4, e.o4);
          chk("done4_align", done4, 1);
          chk("latency", cyc, e.at);
          chk("busy_len", bl, e.bl);
        end
        bl = 0;
      end
      pd = done;
    end
  end

  task automatic kick(input int n, input int c16, input bit o16, input int c4, input bit o4);
    int ne = n == 0 ? 1 : n;
    @(negedge clk);
    gate_len = 16'(n);
    start = 1;
    q.push_back('{c16, o16, c4, o4, cyc + 1 + ne + 2, ne + 2});
    @(negedge clk);
    start = 0;
    gate_len = 16'($urandom);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < n + 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic mode(input int h, input logic l);
    hp = h;
    lvl = l;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int a;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0;
    mode(4, 0);
    kick(80, 10, 0, 10, 0);
    wait_done(80);
    mode(0, 1);
    kick(50, 0, 0, 0, 0);
    wait_done(50);
    mode(2, 0);
    kick(100, 25, 0, 15, 1);
    wait_done(100);
    mode(0, 0);
    kick(30, 0, 0, 0, 0);
    wait_done(30);
    kick(0, 0, 0, 0, 0);
    wait_done(1);
    mode(4, 0);
    kick(80, 10, 0, 10, 0);
    a = cyc;
    repeat (40) @(negedge clk);
    start = 1;
    gate_len = 5;
    @(negedge clk);
    start = 0;
    while (cyc < a + 81) @(negedge clk);
    start = 1;
    gate_len = 3;
    @(negedge clk);
    start = 0;
    wait_done(80);
    repeat (20) @(negedge clk);
    kick(80, 10, 0, 10, 0);
    repeat (30) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", count, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_count4", count4, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    kick(80, 10, 0, 10, 0);
    wait_done(80);
    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
